// File: rtl/video_pkg.sv
// Shared types, mode tables and helpers for the raster timing generator.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  typedef struct packed {
    int h_image;
    int h_front;
    int h_sync;
    int h_back;
    int v_image;
    int v_front;
    int v_sync;
    int v_back;
    bit h_invert;
    bit v_invert;
  } mode_t;

  localparam mode_t MODE_720x480 =
    '{720, 16, 62, 60, 480, 9, 6, 30, 1'b1, 1'b1};

  localparam mode_t MODE_640x480 =
    '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1};

  function automatic int calc_total(
    input int image,
    input int front,
    input int sync,
    input int back
  );
    return image + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_gen_raster_counter.sv
// h/v raster position counter with line and frame wrap plus parallel load.
module raster_counter #(
  parameter int H_TOTAL = 16,
  parameter int V_TOTAL = 8,
  parameter int W       = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         load,
  input  logic [W-1:0] load_h,
  input  logic [W-1:0] load_v,
  output logic [W-1:0] h_q,
  output logic [W-1:0] v_q,
  output logic [W-1:0] h_d,
  output logic [W-1:0] v_d
);

  localparam logic [W-1:0] H_LAST = W'(H_TOTAL - 1);
  localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (load) begin
      h_d = load_h;
      v_d = load_v;
    end else if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with look-ahead scaled fetch
// coordinates; every output is a flop loaded from next-cycle values.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_IMAGE   = MODE_720x480.h_image,
  parameter int H_FRONT   = MODE_720x480.h_front,
  parameter int H_SYNC    = MODE_720x480.h_sync,
  parameter int H_BACK    = MODE_720x480.h_back,
  parameter int V_IMAGE   = MODE_720x480.v_image,
  parameter int V_FRONT   = MODE_720x480.v_front,
  parameter int V_SYNC    = MODE_720x480.v_sync,
  parameter int V_BACK    = MODE_720x480.v_back,
  parameter bit H_INVERT  = MODE_720x480.h_invert,
  parameter bit V_INVERT  = MODE_720x480.v_invert,
  parameter int SCALE_X   = 4,
  parameter int SCALE_Y   = 2,
  parameter int LOOKAHEAD = 2,
  parameter int POS_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             in_hblank,
  output logic             in_vblank,
  output logic             in_image,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count,
  output logic [POS_W-1:0] fetch_x,
  output logic [POS_W-1:0] fetch_y,
  output logic             fetch_valid
);

  localparam int H_TOTAL =
    calc_total(H_IMAGE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    calc_total(V_IMAGE, V_FRONT, V_SYNC, V_BACK);

  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $error("sync width must be nonzero");
  end
  if (LOOKAHEAD < 0 || LOOKAHEAD >= H_TOTAL - H_IMAGE) begin : g_bad_la
    $error("LOOKAHEAD out of range");
  end
  if (SCALE_X < 1 || SCALE_Y < 1) begin : g_bad_scale
    $error("SCALE_X and SCALE_Y must be at least 1");
  end
  if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : g_bad_w
    $error("raster totals do not fit in POS_W");
  end

  // One extra bit so totals equal to 2^POS_W still compare correctly.
  localparam logic [POS_W:0] H_IMG  = (POS_W+1)'(H_IMAGE);
  localparam logic [POS_W:0] V_IMG  = (POS_W+1)'(V_IMAGE);
  localparam logic [POS_W:0] HS_ON  = (POS_W+1)'(H_IMAGE + H_FRONT);
  localparam logic [POS_W:0] HS_OFF =
    (POS_W+1)'(H_IMAGE + H_FRONT + H_SYNC);
  localparam logic [POS_W:0] VS_ON  = (POS_W+1)'(V_IMAGE + V_FRONT);
  localparam logic [POS_W:0] VS_OFF =
    (POS_W+1)'(V_IMAGE + V_FRONT + V_SYNC);

  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] LA_H   = POS_W'(LOOKAHEAD);

  localparam int LA_CL = (LOOKAHEAD < H_IMAGE) ? LOOKAHEAD : H_IMAGE;
  localparam logic [POS_W-1:0] LA_QX   = POS_W'(LA_CL / SCALE_X);
  localparam logic [POS_W-1:0] LA_SX   = POS_W'(LA_CL % SCALE_X);
  localparam logic [POS_W-1:0] SX_LAST = POS_W'(SCALE_X - 1);
  localparam logic [POS_W-1:0] SY_LAST = POS_W'(SCALE_Y - 1);

  state_t state_q, state_d;
  logic   disp_load, adv, eof, load_idle, run_d;

  logic [POS_W-1:0] h_q, v_q, h_d, v_d;
  logic [POS_W-1:0] ah_q, av_q, ah_d, av_d;
  logic [POS_W-1:0] ah_load;

  logic [POS_W-1:0] qx_q, qx_d, sx_q, sx_d;
  logic [POS_W-1:0] qy_q, qy_d, sy_q, sy_d;

  logic        hblank_q, hblank_d, vblank_q, vblank_d;
  logic        image_q, image_d, hsync_q, hsync_d;
  logic        vsync_q, vsync_d, line_q, line_d;
  logic        frame_q, frame_d, fvalid_q, fvalid_d;
  logic [15:0] fcount_q, fcount_d;

  assign eof = (h_q == H_LAST) && (v_q == V_LAST);

  always_comb begin
    state_d   = state_q;
    disp_load = 1'b0;
    adv       = 1'b0;
    unique case (state_q)
      IDLE: begin
        disp_load = 1'b1;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (restart) begin
          disp_load = 1'b1;
        end else begin
          adv = 1'b1;
          if (!enable) state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (restart) begin
          disp_load = 1'b1;
          state_d   = RUN;
        end else if (eof && !enable) begin
          disp_load = 1'b1;
          state_d   = IDLE;
        end else begin
          adv     = 1'b1;
          state_d = enable ? RUN : STOPPING;
        end
      end
      default: begin
        disp_load = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  assign load_idle = (state_d == IDLE);
  assign run_d     = !load_idle;
  assign ah_load   = load_idle ? '0 : LA_H;

  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .W       (POS_W)
  ) u_disp (
    .clk    (clk),
    .rst    (reset),
    .adv    (adv),
    .load   (disp_load),
    .load_h ('0),
    .load_v ('0),
    .h_q    (h_q),
    .v_q    (v_q),
    .h_d    (h_d),
    .v_d    (v_d)
  );

  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .W       (POS_W)
  ) u_ahead (
    .clk    (clk),
    .rst    (reset),
    .adv    (adv),
    .load   (disp_load),
    .load_h (ah_load),
    .load_v ('0),
    .h_q    (ah_q),
    .v_q    (av_q),
    .h_d    (ah_d),
    .v_d    (av_d)
  );

  // Quotients track the ahead position, freezing once it leaves image.
  always_comb begin
    qx_d = qx_q;
    sx_d = sx_q;
    qy_d = qy_q;
    sy_d = sy_q;
    if (disp_load) begin
      qx_d = load_idle ? '0 : LA_QX;
      sx_d = load_idle ? '0 : LA_SX;
      qy_d = '0;
      sy_d = '0;
    end else if (adv) begin
      if (ah_d == '0) begin
        qx_d = '0;
        sx_d = '0;
        if (av_d == '0) begin
          qy_d = '0;
          sy_d = '0;
        end else if ({1'b0, av_q} < V_IMG) begin
          if (sy_q == SY_LAST) begin
            sy_d = '0;
            qy_d = qy_q + 1'b1;
          end else begin
            sy_d = sy_q + 1'b1;
          end
        end
      end else if ({1'b0, ah_q} < H_IMG) begin
        if (sx_q == SX_LAST) begin
          sx_d = '0;
          qx_d = qx_q + 1'b1;
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    hblank_d = !run_d || ({1'b0, h_d} >= H_IMG);
    vblank_d = !run_d || ({1'b0, v_d} >= V_IMG);
    image_d  = !hblank_d && !vblank_d;
    hsync_d  = (run_d && {1'b0, h_d} >= HS_ON
                && {1'b0, h_d} < HS_OFF) ^ H_INVERT;
    vsync_d  = (run_d && {1'b0, v_d} >= VS_ON
                && {1'b0, v_d} < VS_OFF) ^ V_INVERT;
    line_d   = run_d && (h_d == '0);
    frame_d  = line_d && (v_d == '0);
    fcount_d = frame_d ? fcount_q + 16'd1 : fcount_q;
    fvalid_d = run_d && ({1'b0, ah_d} < H_IMG)
               && ({1'b0, av_d} < V_IMG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      qx_q     <= '0;
      sx_q     <= '0;
      qy_q     <= '0;
      sy_q     <= '0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      image_q  <= 1'b0;
      hsync_q  <= H_INVERT;
      vsync_q  <= V_INVERT;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fcount_q <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qx_q     <= qx_d;
      sx_q     <= sx_d;
      qy_q     <= qy_d;
      sy_q     <= sy_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      image_q  <= image_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      fcount_q <= fcount_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign hpos        = h_q;
  assign vpos        = v_q;
  assign in_hblank   = hblank_q;
  assign in_vblank   = vblank_q;
  assign in_image    = image_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_count = fcount_q;
  assign fetch_x     = qx_q;
  assign fetch_y     = qy_q;
  assign fetch_valid = fvalid_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: small 16x8 raster, plain and inverted-sync instances.
module tb_video_timing_gen;

  localparam int W = 10;

  localparam int F_HPOS = 0;
  localparam int F_VPOS = 1;
  localparam int F_HB   = 2;
  localparam int F_VB   = 3;
  localparam int F_IMG  = 4;
  localparam int F_HS   = 5;
  localparam int F_VS   = 6;
  localparam int F_LS   = 7;
  localparam int F_FS   = 8;
  localparam int F_FC   = 9;
  localparam int F_FX   = 10;
  localparam int F_FY   = 11;
  localparam int F_FV   = 12;
  localparam int F_IHS  = 13;
  localparam int F_IVS  = 14;

  typedef struct {
    int cyc;
    int fld;
    int val;
  } chk_t;

  logic clk = 1'b0;
  logic reset, enable, restart;

  logic [W-1:0] hpos, vpos, fetch_x, fetch_y;
  logic         in_hblank, in_vblank, in_image, hsync, vsync;
  logic         line_start, frame_start, fetch_valid;
  logic [15:0]  frame_count;

  logic [W-1:0] i_hpos, i_vpos, i_fx, i_fy;
  logic         i_hb, i_vb, i_img, i_hs, i_vs, i_ls, i_fs, i_fv;
  logic [15:0]  i_fc;

  chk_t sb[$];
  chk_t e;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   done    = 1'b0;
  bit   flushed = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  video_timing_gen #(
    .H_IMAGE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
    .V_IMAGE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .H_INVERT(1'b0), .V_INVERT(1'b0),
    .SCALE_X(2), .SCALE_Y(2), .LOOKAHEAD(3), .POS_W(W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .hpos(hpos), .vpos(vpos),
    .in_hblank(in_hblank), .in_vblank(in_vblank),
    .in_image(in_image), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count),
    .fetch_x(fetch_x), .fetch_y(fetch_y),
    .fetch_valid(fetch_valid)
  );

  video_timing_gen #(
    .H_IMAGE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4),
    .V_IMAGE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .H_INVERT(1'b1), .V_INVERT(1'b1),
    .SCALE_X(2), .SCALE_Y(2), .LOOKAHEAD(3), .POS_W(W)
  ) dut_inv (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart),
    .hpos(i_hpos), .vpos(i_vpos),
    .in_hblank(i_hb), .in_vblank(i_vb),
    .in_image(i_img), .hsync(i_hs), .vsync(i_vs),
    .line_start(i_ls), .frame_start(i_fs),
    .frame_count(i_fc),
    .fetch_x(i_fx), .fetch_y(i_fy),
    .fetch_valid(i_fv)
  );

  function automatic int act(input int f);
    case (f)
      F_HPOS:  return 32'(hpos);
      F_VPOS:  return 32'(vpos);
      F_HB:    return 32'(in_hblank);
      F_VB:    return 32'(in_vblank);
      F_IMG:   return 32'(in_image);
      F_HS:    return 32'(hsync);
      F_VS:    return 32'(vsync);
      F_LS:    return 32'(line_start);
      F_FS:    return 32'(frame_start);
      F_FC:    return 32'(frame_count);
      F_FX:    return 32'(fetch_x);
      F_FY:    return 32'(fetch_y);
      F_FV:    return 32'(fetch_valid);
      F_IHS:   return 32'(i_hs);
      F_IVS:   return 32'(i_vs);
      default: return -1;
    endcase
  endfunction

  function automatic string fname(input int f);
    case (f)
      F_HPOS:  return "hpos";
      F_VPOS:  return "vpos";
      F_HB:    return "in_hblank";
      F_VB:    return "in_vblank";
      F_IMG:   return "in_image";
      F_HS:    return "hsync";
      F_VS:    return "vsync";
      F_LS:    return "line_start";
      F_FS:    return "frame_start";
      F_FC:    return "frame_count";
      F_FX:    return "fetch_x";
      F_FY:    return "fetch_y";
      F_FV:    return "fetch_valid";
      F_IHS:   return "hsync_inv";
      F_IVS:   return "vsync_inv";
      default: return "unknown";
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (act(e.fld) !== e.val) begin
        errors++;
        $display("FAIL %s @cyc %0d: actual %0d required %0d",
                 fname(e.fld), e.cyc, act(e.fld), e.val);
      end
    end
    if (done && !flushed) begin
      flushed = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: actual %0d left required 0",
                 sb.size());
      end
    end
  end

  task automatic push(input int c, input int f, input int v);
    chk_t x;
    x.cyc = c;
    x.fld = f;
    x.val = v;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_idle(input int c, input int fc);
    push(c, F_HPOS, 0);
    push(c, F_VPOS, 0);
    push(c, F_HB, 1);
    push(c, F_VB, 1);
    push(c, F_IMG, 0);
    push(c, F_HS, 0);
    push(c, F_VS, 0);
    push(c, F_IHS, 1);
    push(c, F_IVS, 1);
    push(c, F_LS, 0);
    push(c, F_FS, 0);
    push(c, F_FC, fc);
    push(c, F_FX, 0);
    push(c, F_FY, 0);
    push(c, F_FV, 0);
  endtask

  // Frame starting at cycle c0: 16x8 raster, image 8x4, ahead by 3.
  task automatic push_frame(input int c0);
    int h, v, ah, av, m;
    bit img, fv;
    for (int n = 0; n <= 128; n++) begin
      h   = n % 16;
      v   = (n / 16) % 8;
      m   = n + 3;
      ah  = m % 16;
      av  = (m / 16) % 8;
      img = (h < 8) && (v < 4);
      fv  = (ah < 8) && (av < 4);
      push(c0 + n, F_HPOS, h);
      push(c0 + n, F_VPOS, v);
      push(c0 + n, F_IMG, int'(img));
      push(c0 + n, F_FV, int'(fv));
      push(c0 + n, F_HS, int'(h == 10 || h == 11));
      push(c0 + n, F_IHS, int'(!(h == 10 || h == 11)));
      push(c0 + n, F_VS, int'(v == 5));
      push(c0 + n, F_IVS, int'(v != 5));
      push(c0 + n, F_LS, int'(h == 0));
      push(c0 + n, F_FS, int'(n % 128 == 0));
      push(c0 + n, F_FC, 1 + n / 128);
      if (fv) begin
        push(c0 + n, F_FX, ah / 2);
        push(c0 + n, F_FY, av / 2);
      end
      if (n == 5) push(c0 + n, F_FX, 4);
      if (n == 61) push(c0 + n, F_FY, 2);
    end
  endtask

  int c0, c1, c2, c3, c4, c5;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    restart = 1'b0;
    repeat (3) tick();
    push_idle(cyc, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    push_idle(cyc, 0);

    enable = 1'b1;
    c0 = cyc + 1;
    push_frame(c0);
    c1 = c0 + 128;
    wait_cyc(c1 + 32);

    enable = 1'b0;
    push(c1 + 33, F_HPOS, 1);
    push(c1 + 33, F_VPOS, 2);
    push(c1 + 100, F_HPOS, 4);
    push(c1 + 100, F_VPOS, 6);
    push(c1 + 127, F_HPOS, 15);
    push(c1 + 127, F_VPOS, 7);
    push_idle(c1 + 128, 2);
    push_idle(c1 + 131, 2);
    wait_cyc(c1 + 131);

    enable = 1'b1;
    c2 = cyc + 1;
    push(c2, F_HPOS, 0);
    push(c2, F_FS, 1);
    push(c2, F_FC, 3);
    wait_cyc(c2 + 32);
    enable = 1'b0;
    push(c2 + 64, F_HPOS, 0);
    push(c2 + 64, F_VPOS, 4);
    wait_cyc(c2 + 96);
    enable = 1'b1;
    push(c2 + 127, F_HPOS, 15);
    push(c2 + 127, F_VPOS, 7);
    push(c2 + 128, F_HPOS, 0);
    push(c2 + 128, F_VPOS, 0);
    push(c2 + 128, F_FS, 1);
    push(c2 + 128, F_FC, 4);
    push(c2 + 128, F_IMG, 1);
    push(c2 + 128, F_VB, 0);
    push(c2 + 129, F_HPOS, 1);
    push(c2 + 129, F_FS, 0);
    c3 = c2 + 128;

    wait_cyc(c3 + 53);
    push(c3 + 53, F_HPOS, 5);
    push(c3 + 53, F_VPOS, 3);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    c4 = c3 + 54;
    push(c4, F_HPOS, 0);
    push(c4, F_VPOS, 0);
    push(c4, F_FS, 1);
    push(c4, F_FC, 5);
    push(c4, F_FV, 1);
    push(c4, F_FX, 1);
    push(c4, F_FY, 0);
    push(c4 + 1, F_HPOS, 1);
    push(c4 + 1, F_FS, 0);
    push(c4 + 1, F_FC, 5);

    enable = 1'b0;
    wait_cyc(c4 + 127);
    push(c4 + 127, F_HPOS, 15);
    push(c4 + 127, F_VPOS, 7);
    wait_cyc(c4 + 128);
    push_idle(c4 + 128, 5);
    wait_cyc(c4 + 130);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    push_idle(c4 + 131, 5);
    tick();
    push_idle(c4 + 132, 5);

    enable = 1'b1;
    c5 = cyc + 1;
    push(c5, F_HPOS, 0);
    push(c5, F_FS, 1);
    push(c5, F_FC, 6);
    wait_cyc(c5 + 8);
    push(c5 + 8, F_HPOS, 8);
    push(c5 + 8, F_FC, 6);
    wait_cyc(c5 + 9);
    reset  = 1'b1;
    enable = 1'b0;
    push_idle(c5 + 9, 0);
    tick();
    reset = 1'b0;
    push_idle(cyc, 0);
    tick();
    tick();
    done = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
